// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds, sticky error
// flags, synchronous flush, and a selectable registered or FWFT read port.
module sync_fifo_flex #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       err_clr,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          push, pop;
    logic [AW-1:0] wr_addr, rd_addr;

    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];

    // Pointer MSB disambiguates full from empty when the addresses match.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        push        = wr_en && !full && !flush;
        pop         = rd_en && !empty && !flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // A new error outranks a coincident clear.
        overflow_d  = (wr_en && full)  || (overflow_q  && !err_clr);
        underflow_d = (rd_en && empty) || (underflow_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_addr] <= in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign out = empty ? '0 : mem[rd_addr];
        end else begin : g_reg_read
            logic [WIDTH-1:0] rd_data_q, rd_data_d;

            always_comb begin
                rd_data_d = rd_data_q;
                if (pop) rd_data_d = mem[rd_addr];
            end

            always_ff @(posedge clk) begin
                if (reset) rd_data_q <= '0;
                else       rd_data_q <= rd_data_d;
            end

            assign out = rd_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a registered-read and an FWFT instance share stimulus
// and are compared against a queue-based reference model.
module tb_sync_fifo_flex;

    logic       clk = 1'b0;
    logic       reset, flush, err_clr, wr_en, rd_en;
    logic [7:0] din;

    logic [7:0] u0_out, u1_out;
    logic       u0_full, u0_empty, u0_af, u0_ae, u0_ovf, u0_unf;
    logic       u1_full, u1_empty, u1_af, u1_ae, u1_ovf, u1_unf;
    logic [4:0] u0_count, u1_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_out0 = 8'h00;
    bit         ovf_m = 1'b0;
    bit         unf_m = 1'b0;
    int         txn = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u0 (
        .clk(clk), .reset(reset), .flush(flush), .err_clr(err_clr),
        .wr_en(wr_en), .in(din), .rd_en(rd_en), .out(u0_out),
        .full(u0_full), .empty(u0_empty), .almost_full(u0_af), .almost_empty(u0_ae),
        .count(u0_count), .overflow(u0_ovf), .underflow(u0_unf)
    );

    sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u1 (
        .clk(clk), .reset(reset), .flush(flush), .err_clr(err_clr),
        .wr_en(wr_en), .in(din), .rd_en(rd_en), .out(u1_out),
        .full(u1_full), .empty(u1_empty), .almost_full(u1_af), .almost_empty(u1_ae),
        .count(u1_count), .overflow(u1_ovf), .underflow(u1_unf)
    );

    // Drives one clock of stimulus and advances the reference model.
    task automatic step(input bit wr, input bit rd, input bit fl, input bit ec,
                        input bit rs, input logic [7:0] d);
        int sz;
        bit full_m, empty_m;
        sz      = exp_q.size();
        full_m  = (sz == 16);
        empty_m = (sz == 0);
        wr_en = wr; rd_en = rd; flush = fl; err_clr = ec; reset = rs; din = d;
        @(posedge clk);
        #1;
        if (rs) begin
            exp_q.delete();
            exp_out0 = 8'h00;
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            ovf_m = (wr && full_m)  ? 1'b1 : (ec ? 1'b0 : ovf_m);
            unf_m = (rd && empty_m) ? 1'b1 : (ec ? 1'b0 : unf_m);
            if (fl) begin
                exp_q.delete();
            end else begin
                if (rd && !empty_m) exp_out0 = exp_q.pop_front();
                if (wr && !full_m)  exp_q.push_back(d);
            end
        end
        txn++;
        $display("txn %0d: rst=%0b fl=%0b ec=%0b wr=%0b rd=%0b in=%02h -> count=%0d out0=%02h out1=%02h ovf=%0b unf=%0b",
                 txn, rs, fl, ec, wr, rd, d, u0_count, u0_out, u1_out, u0_ovf, u0_unf);
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (u0_empty !== 1'b1 || u0_full !== 1'b0 || u0_ae !== 1'b1 || u0_af !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got e=%b f=%b ae=%b af=%b required e=1 f=0 ae=1 af=0",
                     u0_empty, u0_full, u0_ae, u0_af);
        end
        checks++;
        if (u0_count !== 5'd0 || u0_out !== 8'h00 || u1_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got count=%0d out0=%h out1=%h required 0 0 0",
                     u0_count, u0_out, u1_out);
        end
        checks++;
        if (u0_ovf !== 1'b0 || u0_unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got ovf=%b unf=%b required 0 0", u0_ovf, u0_unf);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0, 0, 0, 8'(i));
            checks++;
            if (u0_count !== 5'(exp_q.size()) || u0_af !== (exp_q.size() >= 14)
                || u0_full !== (exp_q.size() == 16) || u1_out !== exp_q[0]) begin
                errors++;
                $display("FAIL fill_%0d: got count=%0d af=%b full=%b head1=%h required count=%0d af=%b full=%b head1=%h",
                         i, u0_count, u0_af, u0_full, u1_out, exp_q.size(),
                         exp_q.size() >= 14, exp_q.size() == 16, exp_q[0]);
            end
        end
        step(1, 0, 0, 0, 0, 8'hEE);
        checks++;
        if (u0_count !== 5'd16 || u0_ovf !== 1'b1 || u1_ovf !== 1'b1 || ovf_m !== 1'b1) begin
            errors++;
            $display("FAIL overflow_17th: got count=%0d ovf=%b required count=16 ovf=1", u0_count, u0_ovf);
        end
        step(0, 0, 0, 1, 0, 8'h00);
        checks++;
        if (u0_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b required 0", u0_ovf);
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (u1_out !== exp_q[0]) begin
                errors++;
                $display("FAIL fwft_head_%0d: got %h required %h", i, u1_out, exp_q[0]);
            end
            step(0, 1, 0, 0, 0, 8'h00);
            checks++;
            if (u0_out !== exp_out0 || u0_out !== 8'(i)) begin
                errors++;
                $display("FAIL drain_%0d: got %h required %h", i, u0_out, 8'(i));
            end
        end
        checks++;
        if (u0_empty !== 1'b1 || u0_count !== 5'd0 || u1_out !== 8'h00) begin
            errors++;
            $display("FAIL drained: got empty=%b count=%0d out1=%h required 1 0 00",
                     u0_empty, u0_count, u1_out);
        end
    endtask

    task automatic test_underflow();
        step(0, 1, 0, 0, 0, 8'h00);
        checks++;
        if (u0_unf !== 1'b1 || u0_out !== 8'h10 || u0_count !== 5'd0 || unf_m !== 1'b1) begin
            errors++;
            $display("FAIL underflow: got unf=%b out=%h count=%0d required 1 10 0", u0_unf, u0_out, u0_count);
        end
        step(0, 0, 0, 1, 0, 8'h00);
        checks++;
        if (u0_unf !== 1'b0) begin
            errors++;
            $display("FAIL unf_clear: got %b required 0", u0_unf);
        end
        step(0, 1, 0, 1, 0, 8'h00);
        checks++;
        if (u0_unf !== 1'b1 || u0_unf !== unf_m) begin
            errors++;
            $display("FAIL unf_set_wins: got %b required 1", u0_unf);
        end
        step(0, 0, 0, 1, 0, 8'h00);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 8'(8'h20 + i));
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0, 0, 8'(8'h40 + i));
            checks++;
            if (u0_count !== 5'd8 || u0_out !== exp_out0 || u1_out !== exp_q[0]) begin
                errors++;
                $display("FAIL b2b_%0d: got count=%0d out0=%h out1=%h required 8 %h %h",
                         i, u0_count, u0_out, u1_out, exp_out0, exp_q[0]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 0, 8'h00);
            checks++;
            if (u0_out !== exp_out0 || u0_out !== 8'(8'h4C + i)) begin
                errors++;
                $display("FAIL b2b_drain_%0d: got %h required %h", i, u0_out, 8'(8'h4C + i));
            end
        end
    endtask

    task automatic test_fwft();
        step(1, 0, 0, 0, 0, 8'hA5);
        checks++;
        if (u1_out !== 8'hA5 || u1_empty !== 1'b0) begin
            errors++;
            $display("FAIL fwft_show: got out=%h empty=%b required a5 0", u1_out, u1_empty);
        end
        step(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (u1_out !== 8'hA5) begin
            errors++;
            $display("FAIL fwft_hold: got %h required a5", u1_out);
        end
        step(0, 1, 0, 0, 0, 8'h00);
        checks++;
        if (u1_empty !== 1'b1 || u1_out !== 8'h00 || u0_out !== 8'hA5) begin
            errors++;
            $display("FAIL fwft_pop: got empty=%b out1=%h out0=%h required 1 00 a5", u1_empty, u1_out, u0_out);
        end
    endtask

    task automatic test_flush();
        step(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 8'(8'h60 + i));
        step(1, 0, 1, 0, 0, 8'h99);
        checks++;
        if (u0_count !== 5'd0 || u0_empty !== 1'b1 || u0_ae !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: got count=%0d empty=%b ae=%b required 0 1 1", u0_count, u0_empty, u0_ae);
        end
        checks++;
        if (u0_unf !== 1'b1 || u0_ovf !== 1'b0 || u0_out !== 8'hA5) begin
            errors++;
            $display("FAIL flush_keep: got unf=%b ovf=%b out=%h required 1 0 a5", u0_unf, u0_ovf, u0_out);
        end
        step(1, 0, 0, 0, 0, 8'h77);
        step(0, 1, 0, 1, 0, 8'h00);
        checks++;
        if (u0_out !== 8'h77 || u0_empty !== 1'b1 || u0_unf !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: got out=%h empty=%b unf=%b required 77 1 0", u0_out, u0_empty, u0_unf);
        end
    endtask

    task automatic test_full_simul_reset();
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 8'(8'h80 + i));
        step(1, 1, 0, 0, 0, 8'hFF);
        checks++;
        if (u0_count !== 5'd15 || u0_ovf !== 1'b1 || u0_out !== 8'h80 || u1_out !== 8'h81) begin
            errors++;
            $display("FAIL full_simul: got count=%0d ovf=%b out0=%h out1=%h required 15 1 80 81",
                     u0_count, u0_ovf, u0_out, u1_out);
        end
        step(1, 1, 0, 0, 1, 8'h55);
        checks++;
        if (u0_count !== 5'd0 || u0_empty !== 1'b1 || u0_full !== 1'b0 || u0_out !== 8'h00
            || u0_ovf !== 1'b0 || u0_unf !== 1'b0 || u0_ae !== 1'b1 || u0_af !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got count=%0d e=%b f=%b out=%h ovf=%b unf=%b required 0 1 0 00 0 0",
                     u0_count, u0_empty, u0_full, u0_out, u0_ovf, u0_unf);
        end
        step(1, 0, 0, 0, 0, 8'h3C);
        step(0, 1, 0, 0, 0, 8'h00);
        checks++;
        if (u0_out !== 8'h3C || u0_empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: got out=%h empty=%b required 3c 1", u0_out, u0_empty);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; err_clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        test_reset();
        test_fill_drain();
        test_underflow();
        test_back_to_back();
        test_fwft();
        test_flush();
        test_full_simul_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
